// File: rtl/acc_ctrl_seq_if.sv
// acc_ctrl_seq_if: controller <-> datapath/memory strobe bundle.
// master = sequencer side, slave = datapath/memory side.
interface acc_ctrl_seq_if #(
    parameter int OPC_W = 3
);
    logic             start;
    logic [OPC_W-1:0] opcode;
    logic             acc_zero;
    logic             mem_ack;
    logic             ld_pc;
    logic             inc_pc;
    logic             ld_ir;
    logic             ld_mar;
    logic             mar_sel;
    logic             ld_acc;
    logic             acc_sel;
    logic [1:0]       alu_op;
    logic             mem_rd;
    logic             mem_wr;
    logic             busy;
    logic             halted;
    logic             err;
    logic [2:0]       state_dbg;

    modport master (
        input  start, opcode, acc_zero, mem_ack,
        output ld_pc, inc_pc, ld_ir, ld_mar, mar_sel, ld_acc, acc_sel, alu_op,
               mem_rd, mem_wr, busy, halted, err, state_dbg
    );

    modport slave (
        output start, opcode, acc_zero, mem_ack,
        input  ld_pc, inc_pc, ld_ir, ld_mar, mar_sel, ld_acc, acc_sel, alu_op,
               mem_rd, mem_wr, busy, halted, err, state_dbg
    );
endinterface

// File: rtl/acc_ctrl_seq.sv
// acc_ctrl_seq: fetch/decode/execute sequencer for the accumulator datapath.
// Strobes are decoded combinationally from state, opcode, acc_zero and mem_ack.
module acc_ctrl_seq #(
    parameter int OPC_W    = 3,
    parameter int ADDR_W   = 5,
    parameter int WAIT_MAX = 15
) (
    input logic           clk,
    input logic           clr,
    acc_ctrl_seq_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FA   = 3'd1,
        S_FM   = 3'd2,
        S_DEC  = 3'd3,
        S_EA   = 3'd4,
        S_EM   = 3'd5,
        S_HALT = 3'd6,
        S_BAD  = 3'd7
    } state_t;

    localparam logic [OPC_W-1:0] OP_STA = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_AND = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(7);

    if (OPC_W != 3 || OPC_W + ADDR_W != 8 || WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_bad_cfg
        $error("acc_ctrl_seq: unsupported OPC_W/ADDR_W/WAIT_MAX");
    end

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cnt;
    logic       r_err;
    logic       w_timeout;
    logic       w_last;
    logic       w_memop;
    logic       w_sta;
    logic       w_alu;
    logic       w_mem_state;

    assign w_sta       = bus.opcode == OP_STA;
    assign w_alu       = bus.opcode == OP_ADD || bus.opcode == OP_SUB || bus.opcode == OP_AND;
    assign w_memop     = bus.opcode < OP_JMP;
    assign w_mem_state = r_state == S_FM || r_state == S_EM;
    // r_cnt holds the no-ack cycles already spent, so the WAIT_MAX-th such cycle is the last
    assign w_last      = r_cnt == 8'(WAIT_MAX - 1);

    always_comb begin
        w_next      = r_state;
        w_timeout   = 1'b0;
        bus.ld_pc   = 1'b0;
        bus.inc_pc  = 1'b0;
        bus.ld_ir   = 1'b0;
        bus.ld_mar  = 1'b0;
        bus.mar_sel = 1'b0;
        bus.ld_acc  = 1'b0;
        bus.acc_sel = 1'b0;
        bus.alu_op  = 2'b00;
        bus.mem_rd  = 1'b0;
        bus.mem_wr  = 1'b0;
        case (r_state)
            S_IDLE: w_next = bus.start ? S_FA : S_IDLE;
            S_FA: begin
                bus.ld_mar = 1'b1;
                w_next     = S_FM;
            end
            S_FM: begin
                bus.mem_rd = 1'b1;
                bus.ld_ir  = bus.mem_ack;
                bus.inc_pc = bus.mem_ack;
                w_timeout  = !bus.mem_ack && w_last;
                w_next     = bus.mem_ack ? S_DEC : w_timeout ? S_HALT : S_FM;
            end
            S_DEC: w_next = S_EA;
            S_EA: begin
                bus.ld_mar  = w_memop;
                bus.mar_sel = w_memop;
                bus.ld_pc   = bus.opcode == OP_JMP || (bus.opcode == OP_JZ && bus.acc_zero);
                w_next      = w_memop ? S_EM : bus.opcode == OP_HLT ? S_HALT : S_FA;
            end
            S_EM: begin
                bus.mem_wr  = w_sta;
                bus.mem_rd  = !w_sta;
                bus.ld_acc  = bus.mem_ack && !w_sta;
                bus.acc_sel = bus.mem_ack && w_alu;
                bus.alu_op  = !bus.mem_ack ? 2'b00 :
                              bus.opcode == OP_SUB ? 2'b01 :
                              bus.opcode == OP_AND ? 2'b10 : 2'b00;
                w_timeout   = !bus.mem_ack && w_last;
                w_next      = bus.mem_ack ? S_FA : w_timeout ? S_HALT : S_EM;
            end
            S_HALT: w_next = bus.start ? S_FA : S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_mem_state && !bus.mem_ack) ? r_cnt + 8'd1 : 8'd0;
            if (w_timeout)
                r_err <= 1'b1;
            else if (r_state == S_HALT && bus.start)
                r_err <= 1'b0;
        end
    end

    assign bus.busy      = r_state != S_IDLE && r_state != S_HALT;
    assign bus.halted    = r_state == S_HALT;
    assign bus.err       = r_err;
    assign bus.state_dbg = r_state;
endmodule

// File: tb/tb_acc_ctrl_seq.sv
// tb_acc_ctrl_seq: table-driven per-cycle vectors for acc_ctrl_seq plus
// hand-written timeout, ack-at-limit and asynchronous reset sequences.
module tb_acc_ctrl_seq;
    logic clk = 1'b0;
    logic clr = 1'b0;
    int   checks = 0;
    int   failures = 0;

    acc_ctrl_seq_if #(.OPC_W(3)) bus ();
    acc_ctrl_seq #(.OPC_W(3), .ADDR_W(5), .WAIT_MAX(15)) dut (.clk(clk), .clr(clr), .bus(bus));

    always #5 clk = ~clk;

    // strobe order: ld_pc inc_pc ld_ir ld_mar mar_sel ld_acc acc_sel alu_op[1:0] mem_rd mem_wr
    localparam logic [10:0] Z     = 11'b00000000000;
    localparam logic [10:0] FA    = 11'b00010000000;
    localparam logic [10:0] FMA   = 11'b01100000010;
    localparam logic [10:0] FMW   = 11'b00000000010;
    localparam logic [10:0] EAM   = 11'b00011000000;
    localparam logic [10:0] EAJ   = 11'b10000000000;
    localparam logic [10:0] EMW   = 11'b00000000010;
    localparam logic [10:0] EMLDA = 11'b00000100010;
    localparam logic [10:0] EMSTA = 11'b00000000001;
    localparam logic [10:0] EMADD = 11'b00000110010;
    localparam logic [10:0] EMSUB = 11'b00000110110;
    localparam logic [10:0] EMAND = 11'b00000111010;

    typedef struct {
        logic        start;
        logic [2:0]  opc;
        logic        az;
        logic        ack;
        logic [16:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [16:0] ex(input logic [2:0] st, input logic [10:0] sb, input logic er);
        return {sb, (st >= 3'd1 && st <= 3'd5), st == 3'd6, er, st};
    endfunction

    function automatic logic [16:0] obs();
        return {bus.ld_pc, bus.inc_pc, bus.ld_ir, bus.ld_mar, bus.mar_sel, bus.ld_acc,
                bus.acc_sel, bus.alu_op, bus.mem_rd, bus.mem_wr, bus.busy, bus.halted,
                bus.err, bus.state_dbg};
    endfunction

    task automatic add(input logic s, input logic [2:0] o, input logic z, input logic a,
                       input logic [2:0] st, input logic [10:0] sb, input logic er);
        tbl.push_back('{s, o, z, a, ex(st, sb, er)});
    endtask

    task automatic drive(input logic s, input logic [2:0] o, input logic z, input logic a);
        bus.start    = s;
        bus.opcode   = o;
        bus.acc_zero = z;
        bus.mem_ack  = a;
    endtask

    task automatic chk(input string name, input logic [16:0] exp);
        logic [16:0] got;
        got = obs();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic step(input logic s, input logic [2:0] o, input logic z, input logic a,
                        input string name, input logic [16:0] exp);
        @(negedge clk);
        drive(s, o, z, a);
        #1;
        chk(name, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        // LDA zero-wait with start/ack noise where it must be ignored
        add(0,0,0,0, 0,Z,0);     add(1,0,0,0, 0,Z,0);     add(1,0,0,1, 1,FA,0);
        add(0,0,0,1, 2,FMA,0);   add(1,0,0,1, 3,Z,0);     add(0,0,0,0, 4,EAM,0);
        add(0,0,0,1, 5,EMLDA,0);
        // STA
        add(0,1,0,0, 1,FA,0);    add(0,1,0,1, 2,FMA,0);   add(0,1,0,0, 3,Z,0);
        add(0,1,0,0, 4,EAM,0);   add(0,1,0,1, 5,EMSTA,0);
        // ADD with ack delayed 3 clocks
        add(0,2,0,0, 1,FA,0);    add(0,2,0,1, 2,FMA,0);   add(0,2,0,0, 3,Z,0);
        add(0,2,0,0, 4,EAM,0);   add(0,2,0,0, 5,EMW,0);   add(0,2,0,0, 5,EMW,0);
        add(0,2,0,0, 5,EMW,0);   add(0,2,0,1, 5,EMADD,0);
        // SUB, AND
        add(0,3,0,0, 1,FA,0);    add(0,3,0,1, 2,FMA,0);   add(0,3,0,0, 3,Z,0);
        add(0,3,0,0, 4,EAM,0);   add(0,3,0,1, 5,EMSUB,0);
        add(0,4,0,0, 1,FA,0);    add(0,4,0,1, 2,FMA,0);   add(0,4,0,0, 3,Z,0);
        add(0,4,0,0, 4,EAM,0);   add(0,4,0,1, 5,EMAND,0);
        // JZ taken, JZ not taken, JMP
        add(0,6,1,0, 1,FA,0);    add(0,6,1,1, 2,FMA,0);   add(0,6,1,0, 3,Z,0);
        add(0,6,1,0, 4,EAJ,0);
        add(0,6,0,0, 1,FA,0);    add(0,6,0,1, 2,FMA,0);   add(0,6,0,0, 3,Z,0);
        add(0,6,0,1, 4,Z,0);
        add(0,5,0,0, 1,FA,0);    add(0,5,0,1, 2,FMA,0);   add(0,5,0,0, 3,Z,0);
        add(0,5,0,0, 4,EAJ,0);
        // HLT with start pulses mid-fetch, then restart from HALT
        add(1,7,0,0, 1,FA,0);    add(1,7,0,1, 2,FMA,0);   add(1,7,0,0, 3,Z,0);
        add(1,7,0,0, 4,Z,0);     add(0,7,0,0, 6,Z,0);     add(0,7,0,1, 6,Z,0);
        add(1,7,0,0, 6,Z,0);     add(0,0,0,0, 1,FA,0);

        #1;
        chk("reset_held", ex(3'd0, Z, 1'b0));
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        foreach (tbl[i])
            step(tbl[i].start, tbl[i].opc, tbl[i].az, tbl[i].ack, $sformatf("vec%0d", i), tbl[i].exp);

        // EM timeout after exactly 15 no-ack cycles
        step(0,0,0,1, "to_fm",  ex(3'd2, FMA, 1'b0));
        step(0,0,0,0, "to_dec", ex(3'd3, Z, 1'b0));
        step(0,0,0,0, "to_ea",  ex(3'd4, EAM, 1'b0));
        for (int k = 1; k <= 15; k++)
            step(0,0,0,0, $sformatf("to_em%0d", k), ex(3'd5, EMW, 1'b0));
        step(0,0,0,0, "to_halt",       ex(3'd6, Z, 1'b1));
        step(1,0,0,0, "to_halt_start", ex(3'd6, Z, 1'b1));
        step(0,0,0,0, "to_restart",    ex(3'd1, FA, 1'b0));

        // ack on the 15th EM cycle is a success
        step(0,2,0,1, "a15_fm",  ex(3'd2, FMA, 1'b0));
        step(0,2,0,0, "a15_dec", ex(3'd3, Z, 1'b0));
        step(0,2,0,0, "a15_ea",  ex(3'd4, EAM, 1'b0));
        for (int k = 1; k <= 14; k++)
            step(0,2,0,0, $sformatf("a15_em%0d", k), ex(3'd5, EMW, 1'b0));
        step(0,2,0,1, "a15_ack", ex(3'd5, EMADD, 1'b0));
        step(0,2,0,0, "a15_fa",  ex(3'd1, FA, 1'b0));

        // asynchronous reset mid-FM
        step(0,0,0,0, "rst_fm", ex(3'd2, FMW, 1'b0));
        #2 clr = 1'b0;
        #1 chk("rst_async", ex(3'd0, Z, 1'b0));
        step(1,0,0,1, "rst_hold", ex(3'd0, Z, 1'b0));
        @(negedge clk);
        clr = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        #1 chk("rst_release", ex(3'd0, Z, 1'b0));
        step(1,0,0,0, "rst_idle_start", ex(3'd0, Z, 1'b0));
        step(0,0,0,0, "rst_fa", ex(3'd1, FA, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
